// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mc
//  Brief    : Multi-cycle integer execute unit. Single-cycle base ALU ops plus
//             iterative RV M-extension multiply (shift-add) and divide
//             (restoring), with valid/ready handshakes on input and output.
//  Revision : 1.0  initial release
// ============================================================================
module alu_mc #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out
);

  // Operation codes
  localparam logic [4:0] c_OP_ADD    = 5'd0;
  localparam logic [4:0] c_OP_SUB    = 5'd1;
  localparam logic [4:0] c_OP_AND    = 5'd2;
  localparam logic [4:0] c_OP_OR     = 5'd3;
  localparam logic [4:0] c_OP_XOR    = 5'd4;
  localparam logic [4:0] c_OP_SLL    = 5'd5;
  localparam logic [4:0] c_OP_SRL    = 5'd6;
  localparam logic [4:0] c_OP_SRA    = 5'd7;
  localparam logic [4:0] c_OP_LT     = 5'd8;
  localparam logic [4:0] c_OP_LTU    = 5'd9;
  localparam logic [4:0] c_OP_EQ     = 5'd10;
  localparam logic [4:0] c_OP_MULH   = 5'd17;
  localparam logic [4:0] c_OP_MULHSU = 5'd18;
  localparam logic [4:0] c_OP_DIV    = 5'd20;
  localparam logic [4:0] c_OP_REM    = 5'd22;

  localparam logic [SHW-1:0]  c_CNT_LAST = SHW'(XLEN - 1);
  localparam logic [XLEN-1:0] c_MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SHW-1:0]    r_cnt;
  logic [2:0]        r_op;      // low bits of the captured mul/div op
  logic [XLEN-1:0]   r_mcand;   // multiplicand / divisor magnitude
  logic [XLEN-1:0]   r_hi;      // product high half / partial remainder
  logic [XLEN-1:0]   r_lo;      // multiplier then product low half / quotient
  logic              r_neg_q;   // negate product or quotient at finish
  logic              r_neg_r;   // negate remainder at finish
  logic [XLEN-1:0]   r_out;

  // ---------------------------------------------------------------------------
  // Accept-cycle decode
  // ---------------------------------------------------------------------------
  logic              w_accept;
  logic              w_is_mul;
  logic              w_is_div;
  logic              w_sa;
  logic              w_sb;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_div_zero;
  logic              w_div_ovf;
  logic              w_special;
  logic              w_iter;
  logic [XLEN-1:0]   w_spec_res;
  logic [XLEN-1:0]   w_base;
  logic [SHW-1:0]    w_shamt;

  assign w_accept   = in_valid && (r_state == S_IDLE) && !flush;
  assign w_is_mul   = (op[4:2] == 3'b100);
  assign w_is_div   = (op[4:2] == 3'b101);
  // in1 is signed for MULH, MULHSU, DIV, REM; in2 for MULH, DIV, REM
  assign w_sa       = (op == c_OP_MULH) || (op == c_OP_MULHSU) ||
                      (op == c_OP_DIV)  || (op == c_OP_REM);
  assign w_sb       = (op == c_OP_MULH) || (op == c_OP_DIV) || (op == c_OP_REM);
  assign w_a_neg    = w_sa && in1[XLEN-1];
  assign w_b_neg    = w_sb && in2[XLEN-1];
  assign w_a_mag    = w_a_neg ? (~in1 + 1'b1) : in1;
  assign w_b_mag    = w_b_neg ? (~in2 + 1'b1) : in2;
  assign w_div_zero = w_is_div && (in2 == '0);
  assign w_div_ovf  = ((op == c_OP_DIV) || (op == c_OP_REM)) &&
                      (in1 == c_MOST_NEG) && (in2 == '1);
  assign w_special  = w_div_zero || w_div_ovf;
  assign w_iter     = (w_is_mul || w_is_div) && !w_special;
  assign w_shamt    = in2[SHW-1:0];

  // Special-case divide results: op[1] separates REM/REMU from DIV/DIVU
  always_comb begin
    w_spec_res = '0;
    if (w_div_zero) begin
      w_spec_res = op[1] ? in1 : '1;
    end else if (w_div_ovf) begin
      w_spec_res = op[1] ? '0 : in1;
    end
  end

  // Single-cycle base operation result; unknown codes give zero
  always_comb begin
    w_base = '0;
    case (op)
      c_OP_ADD: w_base = in1 + in2;
      c_OP_SUB: w_base = in1 - in2;
      c_OP_AND: w_base = in1 & in2;
      c_OP_OR:  w_base = in1 | in2;
      c_OP_XOR: w_base = in1 ^ in2;
      c_OP_SLL: w_base = in1 << w_shamt;
      c_OP_SRL: w_base = in1 >> w_shamt;
      c_OP_SRA: w_base = $unsigned($signed(in1) >>> w_shamt);
      c_OP_LT:  w_base = {{(XLEN-1){1'b0}}, ($signed(in1) < $signed(in2))};
      c_OP_LTU: w_base = {{(XLEN-1){1'b0}}, (in1 < in2)};
      c_OP_EQ:  w_base = {{(XLEN-1){1'b0}}, (in1 == in2)};
      default:  w_base = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Iteration datapath
  // ---------------------------------------------------------------------------
  logic [XLEN:0]     w_sum;
  logic [XLEN-1:0]   w_mul_hi;
  logic [XLEN-1:0]   w_mul_lo;
  logic [XLEN:0]     w_shift;
  logic [XLEN:0]     w_diff;
  logic              w_ge;
  logic [XLEN-1:0]   w_div_hi;
  logic [XLEN-1:0]   w_div_lo;
  logic [XLEN-1:0]   w_hi_nxt;
  logic [XLEN-1:0]   w_lo_nxt;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fin;

  // Shift-add: add multiplicand on multiplier LSB, shift the pair right
  assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
  assign w_mul_hi = w_sum[XLEN:1];
  assign w_mul_lo = {w_sum[0], r_lo[XLEN-1:1]};

  // Restoring divide: bring in next dividend bit, trial-subtract the divisor.
  // The shifted remainder is always below twice the divisor, so bit XLEN of
  // the difference is a clean borrow flag.
  assign w_shift  = {r_hi, r_lo[XLEN-1]};
  assign w_diff   = w_shift - {1'b0, r_mcand};
  assign w_ge     = !w_diff[XLEN];
  assign w_div_hi = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_div_lo = {r_lo[XLEN-2:0], w_ge};

  assign w_hi_nxt = r_op[2] ? w_div_hi : w_mul_hi;
  assign w_lo_nxt = r_op[2] ? w_div_lo : w_mul_lo;

  // Sign fix-up applied to the values produced by the last iteration
  assign w_prod   = r_neg_q ? (~{w_hi_nxt, w_lo_nxt} + 1'b1) : {w_hi_nxt, w_lo_nxt};
  assign w_quo    = r_neg_q ? (~w_lo_nxt + 1'b1) : w_lo_nxt;
  assign w_rem    = r_neg_r ? (~w_hi_nxt + 1'b1) : w_hi_nxt;

  // Final result selection: MUL takes the low half, MULH* the high half
  always_comb begin
    w_fin = '0;
    if (r_op[2]) begin
      w_fin = r_op[1] ? w_rem : w_quo;
    end else begin
      w_fin = (r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; flush overrides every other transition
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_state_nxt = w_iter ? S_BUSY : S_DONE;
      S_BUSY: if (r_cnt == c_CNT_LAST) w_state_nxt = S_DONE;
      S_DONE: if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) begin
      w_state_nxt = S_IDLE;
    end
  end

  // Operand capture, iteration and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_op    <= '0;
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_out   <= '0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_op    <= op[2:0];
      r_mcand <= w_b_mag;
      r_hi    <= '0;
      r_lo    <= w_a_mag;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      if (!w_iter) begin
        r_out <= w_special ? w_spec_res : w_base;
      end
    end else if ((r_state == S_BUSY) && !flush) begin
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      r_cnt <= r_cnt + SHW'(1);
      if (r_cnt == c_CNT_LAST) begin
        r_out <= w_fin;
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out       = r_out;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_alu_mc
//  Brief    : Self-checking bench for alu_mc (XLEN=32 main, XLEN=64 spot).
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [4:0]  op = '0;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out;

  logic        flush64 = 1'b0;
  logic        in_valid64 = 1'b0;
  logic        out_ready64 = 1'b1;
  logic [4:0]  op64 = '0;
  logic [63:0] a64 = '0;
  logic [63:0] b64 = '0;
  logic        in_ready64;
  logic        out_valid64;
  logic [63:0] out64;

  always #5 clk = ~clk;

  alu_mc #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .op(op), .in1(in1), .in2(in2),
    .out_valid(out_valid), .out_ready(out_ready), .out(out)
  );

  alu_mc #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush64), .in_valid(in_valid64),
    .in_ready(in_ready64), .op(op64), .in1(a64), .in2(b64),
    .out_valid(out_valid64), .out_ready(out_ready64), .out(out64)
  );

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t        vecs[$];
  logic [63:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic add_vec(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, input int lat);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.exp = e; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Issue one op, push its expected result, then wait for and score the result
  task automatic do_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e, input int lat, input string nm);
    int n;
    logic [63:0] want;
    @(negedge clk);
    check({nm, " in_ready"}, 64'(in_ready), 64'd1);
    op = o; in1 = a; in2 = b; in_valid = 1'b1; out_ready = 1'b1;
    exp_q.push_back(64'(e));
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    want = exp_q.pop_front();
    check({nm, " latency"}, 64'(n), 64'(lat));
    check({nm, " out"}, 64'(out), want);
  endtask

  task automatic do_op64(input logic [4:0] o, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] e, input int lat, input string nm);
    int n;
    logic [63:0] want;
    @(negedge clk);
    op64 = o; a64 = a; b64 = b; in_valid64 = 1'b1; out_ready64 = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    in_valid64 = 1'b0;
    n = 1;
    while (!out_valid64 && n < 200) begin
      @(negedge clk);
      n++;
    end
    want = exp_q.pop_front();
    check({nm, " latency"}, 64'(n), 64'(lat));
    check({nm, " out"}, out64, want);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n;
    bit  seen;

    // Base ops
    add_vec(5'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1);
    add_vec(5'd1,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1);
    add_vec(5'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1);
    add_vec(5'd3,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1);
    add_vec(5'd4,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1);
    add_vec(5'd5,  32'h00000001, 32'h00000024, 32'h00000010, 1);
    add_vec(5'd6,  32'h80000000, 32'h0000001F, 32'h00000001, 1);
    add_vec(5'd7,  32'h80000000, 32'h00000021, 32'hC0000000, 1);
    add_vec(5'd8,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1);
    add_vec(5'd9,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1);
    add_vec(5'd10, 32'h00000007, 32'h00000007, 32'h00000001, 1);
    add_vec(5'd11, 32'h00000007, 32'h00000007, 32'h00000000, 1);
    add_vec(5'd31, 32'h12345678, 32'h00000001, 32'h00000000, 1);
    // Multiply
    add_vec(5'd16, 32'h12345678, 32'h9ABCDEF0, 32'h242D2080, 33);
    add_vec(5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    add_vec(5'd17, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 33);
    add_vec(5'd18, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    add_vec(5'd16, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 33);
    // Divide
    add_vec(5'd20, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33);
    add_vec(5'd22, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33);
    add_vec(5'd21, 32'd100,      32'd7,        32'd14,       33);
    add_vec(5'd23, 32'd100,      32'd7,        32'd2,        33);
    add_vec(5'd20, 32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 33);
    add_vec(5'd22, 32'd20,       32'hFFFFFFFD, 32'd2,        33);
    add_vec(5'd21, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33);
    // Special cases
    add_vec(5'd20, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    add_vec(5'd22, 32'd5,        32'd0,        32'd5,        1);
    add_vec(5'd21, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    add_vec(5'd23, 32'd5,        32'd0,        32'd5,        1);
    add_vec(5'd20, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    add_vec(5'd22, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

    // Reset state
    #12;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out", 64'(out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat,
            $sformatf("vec%0d", i));
    end

    // Backpressure: result held, no new accept while DONE
    @(negedge clk);
    op = 5'd0; in1 = 32'd3; in2 = 32'd4; in_valid = 1'b1; out_ready = 1'b0;
    exp_q.push_back(64'd7);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("bp latency", 64'(n), 64'd1);
    check("bp out", 64'(out), exp_q.pop_front());
    op = 5'd0; in1 = 32'd100; in2 = 32'd1; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("bp hold out %0d", k), 64'(out), 64'd7);
      check($sformatf("bp hold in_ready %0d", k), 64'(in_ready), 64'd0);
      check($sformatf("bp hold out_valid %0d", k), 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("bp drained out_valid", 64'(out_valid), 64'd0);
    check("bp drained out held", 64'(out), 64'd7);
    @(negedge clk);
    check("bp no extra accept", 64'(out_valid), 64'd0);

    // Flush at BUSY cycle 5
    op = 5'd21; in1 = 32'd1000; in2 = 32'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 2; k <= 5; k++) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush in_ready", 64'(in_ready), 64'd1);
    check("flush out_valid", 64'(out_valid), 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("flush out_valid never", 64'(seen), 64'd0);
    check("flush out held", 64'(out), 64'd7);

    // Flush together with in_valid: not accepted
    op = 5'd0; in1 = 32'd1; in2 = 32'd1; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flush+valid in_ready", 64'(in_ready), 64'd1);
    check("flush+valid out_valid", 64'(out_valid), 64'd0);

    do_op(5'd0, 32'd10, 32'd20, 32'd30, 1, "post flush");

    // Asynchronous reset mid-DIV
    @(negedge clk);
    op = 5'd20; in1 = 32'hFFFFFFF9; in2 = 32'd2; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("mid div busy", 64'(in_ready), 64'd0);
    #1 rst_n = 1'b0;
    #1;
    check("async rst in_ready", 64'(in_ready), 64'd1);
    check("async rst out_valid", 64'(out_valid), 64'd0);
    check("async rst out", 64'(out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(5'd20, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, "post reset div");

    // XLEN=64 spot checks
    do_op64(5'd19, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
            64'hFFFFFFFFFFFFFFFE, 65, "x64 mulhu");
    do_op64(5'd5, 64'h1, 64'h47, 64'h80, 1, "x64 sll");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised execute unit for the core's integer pipeline: the single-cycle base ALU operation set widened to XLEN bits, plus the RV M-extension multiply/divide set executed iteratively. The unit sits between decode/issue and writeback. It accepts one operation at a time over a valid/ready handshake and returns a registered result over a second valid/ready handshake. Base operations complete in 1 cycle; multiply/divide take XLEN+1 cycles.

## Interface
- XLEN, 32: operand/result width; legal values 32, 64.
- SHW, $clog2(XLEN): shift-amount width, derived; not overridden.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort of any in-flight or pending operation.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept; high only in IDLE.
- op  in  5  operation code (see Operation).
- in1, in2  in  XLEN  operands.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out  out  XLEN  result; held stable while out_valid && !out_ready.

## Operation
- Op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 LT (signed), 9 LTU, 10 EQ; 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU. Any other code yields 0 with base-op latency.
- Shifts use only in2[SHW-1:0]. Compares return {XLEN-1 zeros, bit}. All arithmetic is modulo 2^XLEN.
- Multiply: shift-add, one multiplier bit per cycle over the 2*XLEN product. MUL returns the low half. MULH returns the high half with both operands signed; MULHSU with in1 signed and in2 unsigned; MULHU with both unsigned. Signed operands are converted to magnitudes on accept, and the product is negated at finish when the signs differ.
- Divide: restoring, one quotient bit per cycle on magnitudes. Quotient sign = sign(in1) xor sign(in2); remainder takes the sign of in1.
- Special cases, resolved in the accept cycle with base-op latency:
  - Divide by zero: DIV/DIVU = all ones; REM/REMU = in1.
  - Signed overflow (in1 = most-negative, in2 = -1): DIV = in1; REM = 0.
- FSM:
  - IDLE: on in_valid, capture operands. Base op or special case → DONE. Mul/div → BUSY with cnt = 0.
  - BUSY: one iteration per cycle, cnt++. When cnt = XLEN-1 → DONE, with sign fix-up applied on that edge.
  - DONE: out_valid = 1. On out_ready → IDLE.
- flush: from any state, the next state is IDLE and out_valid deasserts on the following edge. flush takes priority over in_valid and out_ready in the same cycle; an operation presented together with flush is not accepted.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, out 0, cnt 0, internal registers 0. Reset asserted mid-operation discards the operation immediately.
- Base op or special case accepted at cycle N → out_valid at N+1.
- Mul/div accepted at N → BUSY during N+1..N+XLEN → out_valid at N+XLEN+1.
- in_ready = (state == IDLE), a combinational decode of registered state only. There is no same-cycle result-drain-plus-accept, so back-to-back base ops give one result every 2 cycles.
- out holds its value until the next DONE entry; it is not cleared on handshake.
- Operands may change freely after the accept cycle.

## Test plan
- Base ops, XLEN=32:
  - ADD 0xFFFFFFFF+1 → 0x00000000.
  - SRA 0x80000000 by in2=0x21 (uses shamt 1) → 0xC0000000.
  - LT -1 vs 1 → 1; LTU -1 vs 1 → 0.
  - Each result has out_valid exactly 1 cycle after accept.
- Multiply:
  - MUL 0x12345678*0x9ABCDEF0 → 0x242D2080.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFE.
  - MULH −2*3 → 0xFFFFFFFF.
  - MULHSU −1*0xFFFFFFFF → 0xFFFFFFFF.
  - Each result has out_valid at accept+33.
- Divide:
  - DIV −7/2 → 0xFFFFFFFD (−3); REM −7/2 → 0xFFFFFFFF (−1).
  - DIVU 100/7 → 14; REMU 100/7 → 2.
  - Latency 33 cycles.
- Special cases:
  - DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000/−1 → 0x80000000; REM 0x80000000/−1 → 0.
  - All at 1-cycle latency.
- Backpressure and flush:
  - Hold out_ready=0 for 10 cycles after DONE: out stable, in_ready=0, and a new in_valid is not accepted.
  - Assert flush at BUSY cycle 5: IDLE next cycle, out_valid never rises.
  - The next op is accepted normally.
- Reset: deassert rst_n asynchronously mid-DIV → in_ready=1, out_valid=0, out=0 immediately, without waiting for a clock edge.
- XLEN=64 regression: MULHU (2^64−1)² → 0xFFFFFFFFFFFFFFFE with latency 65; SLL uses in2[5:0].
